// File: rtl/rv32i_exec_decode.sv
// Execute/decode slice: control word, ALU result and branch flags, plus a sticky illegal-opcode flag.
// Latency: combinational outputs with no latency; illegal_seen is registered. There is no backpressure.
module rv32i_exec_decode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    output logic [17:0] control,
    output logic [31:0] alu_out,
    output logic        br_eq,
    output logic        br_lt,
    output logic        illegal_seen
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;
    localparam logic [3:0] ALU_ADDC = 4'd11;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       unused_inst_bits;

    assign opcode           = inst[6:0];
    assign funct3           = inst[14:12];
    assign funct7_b5        = inst[30];
    assign unused_inst_bits = ^{inst[31], inst[29:15], inst[11:7]};

    logic [2:0] dec_imm_sel;
    logic       dec_reg_we;
    logic       dec_cmpop;
    logic       dec_mux1;
    logic       dec_mux2;
    logic [3:0] dec_aluop;
    logic [3:0] dec_dmem;
    logic [1:0] dec_wb;
    logic       dec_jump;
    logic       dec_branch;
    logic       dec_illegal;

    function automatic logic [3:0] alu_map(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        dec_imm_sel = 3'd0;
        dec_reg_we  = 1'b0;
        dec_cmpop   = 1'b0;
        dec_mux1    = 1'b0;
        dec_mux2    = 1'b0;
        dec_aluop   = ALU_ADD;
        dec_dmem    = 4'd0;
        dec_wb      = 2'd0;
        dec_jump    = 1'b0;
        dec_branch  = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            OP_R: begin
                dec_reg_we = 1'b1;
                dec_wb     = 2'd1;
                dec_aluop  = alu_map(funct3, funct7_b5);
            end
            OP_IMM: begin
                dec_mux1   = 1'b1;
                dec_reg_we = 1'b1;
                dec_wb     = 2'd1;
                // Only SRAI reads funct7[5]; for ADDI that bit is immediate data.
                dec_aluop  = alu_map(funct3, (funct3 == 3'b101) && funct7_b5);
            end
            OP_LOAD: begin
                dec_mux1   = 1'b1;
                dec_dmem   = {1'b0, funct3};
                dec_reg_we = 1'b1;
            end
            OP_STORE: begin
                dec_imm_sel = 3'd1;
                dec_mux1    = 1'b1;
                dec_dmem    = {1'b1, funct3};
            end
            OP_BRANCH: begin
                dec_imm_sel = 3'd2;
                dec_mux1    = 1'b1;
                dec_mux2    = 1'b1;
                dec_cmpop   = funct3[1];
                dec_branch  = 1'b1;
            end
            OP_JAL: begin
                dec_imm_sel = 3'd4;
                dec_mux1    = 1'b1;
                dec_mux2    = 1'b1;
                dec_jump    = 1'b1;
                dec_reg_we  = 1'b1;
                dec_wb      = 2'd2;
            end
            OP_JALR: begin
                dec_mux1   = 1'b1;
                dec_aluop  = ALU_ADDC;
                dec_jump   = 1'b1;
                dec_reg_we = 1'b1;
                dec_wb     = 2'd2;
            end
            OP_LUI: begin
                dec_imm_sel = 3'd3;
                dec_mux1    = 1'b1;
                dec_aluop   = ALU_PASS;
                dec_reg_we  = 1'b1;
                dec_wb      = 2'd1;
            end
            OP_AUIPC: begin
                dec_imm_sel = 3'd3;
                dec_mux1    = 1'b1;
                dec_mux2    = 1'b1;
                dec_reg_we  = 1'b1;
                dec_wb      = 2'd1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    assign br_eq = (rs1_data == rs2_data);
    assign br_lt = dec_cmpop ? (rs1_data < rs2_data)
                             : ($signed(rs1_data) < $signed(rs2_data));

    logic taken;
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:        taken = br_eq;
            3'b001:        taken = ~br_eq;
            3'b100, 3'b110: taken = br_lt;
            3'b101, 3'b111: taken = ~br_lt;
            default:       taken = 1'b0;
        endcase
    end

    logic pcmux_sel;
    assign pcmux_sel = dec_jump | (dec_branch & taken);

    // Redirect, register write and store enable are gated by reset so nothing commits during reset.
    assign control = {pcmux_sel & rst_n, dec_imm_sel, dec_reg_we & rst_n, dec_cmpop,
                      dec_mux1, dec_mux2, dec_aluop,
                      dec_dmem[3] & rst_n, dec_dmem[2:0], dec_wb};

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] sum;
    logic [4:0]  shamt;

    assign op_a  = dec_mux2 ? pc : rs1_data;
    assign op_b  = dec_mux1 ? imm : rs2_data;
    assign sum   = op_a + op_b;
    assign shamt = op_b[4:0];

    always_comb begin
        alu_out = 32'd0;
        case (dec_aluop)
            ALU_ADD:  alu_out = sum;
            ALU_SUB:  alu_out = op_a - op_b;
            ALU_SLL:  alu_out = op_a << shamt;
            ALU_SLT:  alu_out = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_out = {31'd0, op_a < op_b};
            ALU_XOR:  alu_out = op_a ^ op_b;
            ALU_SRL:  alu_out = op_a >> shamt;
            ALU_SRA:  alu_out = $unsigned($signed(op_a) >>> shamt);
            ALU_OR:   alu_out = op_a | op_b;
            ALU_AND:  alu_out = op_a & op_b;
            ALU_PASS: alu_out = op_b;
            ALU_ADDC: alu_out = {sum[31:1], 1'b0};
            default:  alu_out = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_seen <= 1'b0;
        end else if (dec_illegal) begin
            illegal_seen <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rv32i_exec_decode.sv
// Bench for rv32i_exec_decode: scoreboarded decode/ALU/branch vectors plus sticky-flag and reset checks.
module tb_rv32i_exec_decode;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [17:0] control;
    logic [31:0] alu_out;
    logic        br_eq;
    logic        br_lt;
    logic        illegal_seen;

    rv32i_exec_decode dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst         (inst),
        .pc           (pc),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .imm          (imm),
        .control      (control),
        .alu_out      (alu_out),
        .br_eq        (br_eq),
        .br_lt        (br_lt),
        .illegal_seen (illegal_seen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        string       tag;
        logic [17:0] ctrl;
        logic [31:0] alu;
        logic        eq;
        logic        lt;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
        return {f7, 5'd2, 5'd1, f3, 5'd3, op};
    endfunction

    // Drive one instruction just after a rising edge and log what it should produce.
    task automatic drive(input string tag, input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic [17:0] ec, input logic [31:0] ea, input logic ee, input logic el);
        exp_t e;
        @(posedge clk);
        #1;
        inst = i; pc = p; rs1_data = a; rs2_data = b; imm = im;
        e.tag = tag; e.ctrl = ec; e.alu = ea; e.eq = ee; e.lt = el;
        sb_q.push_back(e);
    endtask

    task automatic compare_next();
        exp_t e;
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({e.tag, "_ctrl"}, {14'd0, control}, {14'd0, e.ctrl});
            check({e.tag, "_alu"}, alu_out, e.alu);
            check({e.tag, "_eq"}, {31'd0, br_eq}, {31'd0, e.eq});
            check({e.tag, "_lt"}, {31'd0, br_lt}, {31'd0, e.lt});
            check({e.tag, "_ill"}, {31'd0, illegal_seen}, 32'd0);
        end
    endtask

    task automatic run(input string tag, input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic [17:0] ec, input logic [31:0] ea, input logic ee, input logic el);
        drive(tag, i, p, a, b, im, ec, ea, ee, el);
        compare_next();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        inst = enc(7'h00, 3'b000, 7'b0110011);
        pc = 32'h0; rs1_data = 32'd5; rs2_data = 32'd7; imm = 32'h0;
        #2;
        check("rst_ill", {31'd0, illegal_seen}, 32'd0);
        check("rst_ctrl_masked", {14'd0, control}, 32'h0000_0001);
        @(posedge clk);
        #1;
        inst = 32'h0000_0073;
        @(posedge clk);
        #1;
        check("rst_dominates", {31'd0, illegal_seen}, 32'd0);
        inst = enc(7'h00, 3'b000, 7'b0110011);
        @(negedge clk);
        rst_n = 1'b1;

        run("add",  enc(7'h00, 3'b000, 7'b0110011), 32'h0, 32'd5, 32'd7, 32'h0, 18'h02001, 32'd12, 1'b0, 1'b1);
        run("sub",  enc(7'h20, 3'b000, 7'b0110011), 32'h0, 32'd0, 32'd1, 32'h0, 18'h02041, 32'hFFFF_FFFF, 1'b0, 1'b1);
        run("sra",  enc(7'h20, 3'b101, 7'b0110011), 32'h0, 32'h8000_0000, 32'd4, 32'h0, 18'h021C1, 32'hF800_0000, 1'b0, 1'b1);
        run("srl",  enc(7'h00, 3'b101, 7'b0110011), 32'h0, 32'h8000_0000, 32'd4, 32'h0, 18'h02181, 32'h0800_0000, 1'b0, 1'b1);
        run("blt",  enc(7'h00, 3'b100, 7'b1100011), 32'h100, 32'hFFFF_FFFF, 32'd1, 32'd8, 18'h28C00, 32'h108, 1'b0, 1'b1);
        run("bltu", enc(7'h00, 3'b110, 7'b1100011), 32'h100, 32'hFFFF_FFFF, 32'd1, 32'd8, 18'h09C00, 32'h108, 1'b0, 1'b0);
        run("bge_eq", enc(7'h00, 3'b101, 7'b1100011), 32'h200, 32'd3, 32'd3, 32'hFFFF_FFFC, 18'h28C00, 32'h1FC, 1'b1, 1'b0);
        run("br010", enc(7'h00, 3'b010, 7'b1100011), 32'h200, 32'd3, 32'd3, 32'd4, 18'h09C00, 32'h204, 1'b1, 1'b0);
        run("jalr", enc(7'h00, 3'b000, 7'b1100111), 32'h40, 32'h101, 32'd0, 32'd2, 18'h22AC2, 32'h102, 1'b0, 1'b0);
        run("jal",  {25'h0, 7'b1101111}, 32'h40, 32'd0, 32'd0, 32'h10, 18'h32C02, 32'h50, 1'b1, 1'b0);
        run("lui",  {20'h12345, 5'd3, 7'b0110111}, 32'h40, 32'd9, 32'd1, 32'h1234_5000, 18'h0EA81, 32'h1234_5000, 1'b0, 1'b0);
        run("auipc", {20'h00001, 5'd3, 7'b0010111}, 32'h40, 32'd9, 32'd1, 32'h0000_1000, 18'h0EC01, 32'h1040, 1'b0, 1'b0);
        run("sw",   enc(7'h00, 3'b010, 7'b0100011), 32'h0, 32'h1000, 32'd1, 32'd4, 18'h04828, 32'h1004, 1'b0, 1'b0);
        run("lbu",  enc(7'h00, 3'b100, 7'b0000011), 32'h0, 32'h1000, 32'h1000, 32'd8, 18'h02810, 32'h1008, 1'b1, 1'b0);
        run("addi_neg", enc(7'h7F, 3'b000, 7'b0010011), 32'h0, 32'd10, 32'd0, 32'hFFFF_FFFF, 18'h02801, 32'd9, 1'b0, 1'b0);
        run("ecall", 32'h0000_0073, 32'h0, 32'd2, 32'd3, 32'h0, 18'h00000, 32'd5, 1'b0, 1'b1);

        @(posedge clk);
        #1;
        check("ill_set", {31'd0, illegal_seen}, 32'd1);
        inst = enc(7'h00, 3'b000, 7'b0110011);
        rs1_data = 32'd5; rs2_data = 32'd7;
        @(posedge clk);
        #1;
        check("ill_sticky", {31'd0, illegal_seen}, 32'd1);
        inst = {25'h0, 7'b1101111};
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ill", {31'd0, illegal_seen}, 32'd0);
        check("midrst_we", {31'd0, control[13]}, 32'd0);
        check("midrst_pcmux", {31'd0, control[17]}, 32'd0);
        inst = enc(7'h00, 3'b010, 7'b0100011);
        #1;
        check("midrst_store", {31'd0, control[5]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_store", {31'd0, control[5]}, 32'd1);

        check("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rv32i_exec_decode.md
# rv32i_exec_decode

Combinational execute/decode slice of the single-cycle RV32I core. It takes the fetched instruction and operands and produces three things: the 18-bit control word, the ALU result, and the branch-compare flags. It also keeps one registered status bit. It sits between the register file / immediate generator and the PC mux, DMEM and writeback mux. It replaces the separate ALU, BranchComp and Control blocks with one unit.

## Interface
No parameters.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- inst  in  32  current instruction
- pc  in  32  current PC
- rs1_data, rs2_data  in  32 each  register-file read data
- imm  in  32  sign-extended immediate from the external immediate generator
- control  out  18  control word:
  - [17] pcmux_sel
  - [16:14] imm_sel
  - [13] reg_we
  - [12] cmpop
  - [11] alumux1_sel
  - [10] alumux2_sel
  - [9:6] aluop
  - [5:2] dmem_sel
  - [1:0] wbmux_sel
- alu_out  out  32  ALU result
- br_eq, br_lt  out  1 each  branch-compare flags
- illegal_seen  out  1  sticky illegal-opcode flag (registered)

## Operation
- Operand muxes:
  - A = alumux2_sel ? pc : rs1_data
  - B = alumux1_sel ? imm : rs2_data
- aluop encoding: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B, 11 ADD_CLR0 (A+B with bit0 cleared), 12-15 produce 0.
  - Shifts use B[4:0].
  - SLT and SLTU output 32'd1 or 32'd0.
  - All arithmetic is modulo 2^32.
- Branch compare:
  - br_eq = (rs1_data == rs2_data).
  - br_lt compares rs1_data < rs2_data, unsigned when cmpop = 1, signed when cmpop = 0.
- imm_sel encoding: 0 I, 1 S, 2 B, 3 U, 4 J.
- wbmux_sel encoding: 0 DMEM, 1 ALU, 2 PC+4.
- dmem_sel = {store, funct3} for loads and stores; 0 otherwise.
- Decode by inst[6:0]. Every field not listed below is 0.
  - R-type 0110011: reg_we = 1, wb = 1. aluop from {funct7[5], funct3}: 000 gives ADD (SUB if funct7[5] = 1), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA (by funct7[5]), 110 OR, 111 AND.
  - OP-IMM 0010011: imm_sel I, alumux1 = 1, reg_we = 1, wb = 1. aluop uses the same map, except funct7[5] is honoured only for funct3 = 101 (SRAI). ADDI is never SUB.
  - LOAD 0000011: imm_sel I, alumux1 = 1, ADD, dmem_sel = {0, funct3}, reg_we = 1, wb = 0.
  - STORE 0100011: imm_sel S, alumux1 = 1, ADD, dmem_sel = {1, funct3}.
  - BRANCH 1100011: imm_sel B, alumux1 = 1, alumux2 = 1, ADD, cmpop = funct3[1].
    - pcmux_sel = taken: BEQ eq; BNE !eq; BLT/BLTU lt; BGE/BGEU !lt.
    - funct3 010/011 gives not-taken.
  - JAL 1101111: imm_sel J, alumux1 = 1, alumux2 = 1, ADD, pcmux_sel = 1, reg_we = 1, wb = 2.
  - JALR 1100111: imm_sel I, alumux1 = 1, ADD_CLR0, pcmux_sel = 1, reg_we = 1, wb = 2.
  - LUI 0110111: imm_sel U, alumux1 = 1, PASS_B, reg_we = 1, wb = 1.
  - AUIPC 0010111: imm_sel U, alumux1 = 1, alumux2 = 1, ADD, reg_we = 1, wb = 1.
  - Any other opcode (including FENCE/SYSTEM): control = 18'h0, which executes as a NOP and advances to PC+4. The opcode is flagged illegal.
- While rst_n = 0, control[17], control[13] and control[5] are forced to 0, asynchronously. No write or redirect can occur during reset.

## Timing
- control, alu_out, br_eq and br_lt are purely combinational and settle within the same cycle. There is no latency.
- illegal_seen:
  - Async cleared to 0 by rst_n = 0.
  - Set on a rising clk edge when rst_n = 1 and the opcode is illegal.
  - Holds until the next reset.
  - Reset dominates a simultaneous illegal decode.
- All other outputs have no reset value beyond the forcing described above.

## Test plan
- `add x3,x1,x2` with rs1 = 5, rs2 = 7 → control has reg_we = 1, wb = 1, aluop = 0; alu_out = 12.
- `sub` with rs1 = 0, rs2 = 1 → alu_out = 32'hFFFFFFFF. SRA of 32'h80000000 by 4 → 32'hF8000000; SRL of the same → 32'h08000000.
- `blt` with rs1 = 32'hFFFFFFFF, rs2 = 1 → br_lt = 1, pcmux_sel = 1. `bltu` on the same operands → cmpop = 1, br_lt = 0, pcmux_sel = 0.
- `jalr` with rs1 = 32'h101, imm = 2 → alu_out = 32'h102, pcmux_sel = 1, wb = 2. `lui` with imm = 32'h12345000 → alu_out = 32'h12345000.
- `sw` → dmem_sel = 4'b1010, reg_we = 0. `lbu` → dmem_sel = 4'b0100, wb = 0.
- Opcode 7'b1110011 → control = 0, then illegal_seen = 1 after the next clk edge. Assert rst_n = 0 mid-cycle → illegal_seen = 0 immediately and reg_we = 0.
